// File: rtl/dot_row_acc_pkg.sv
// Shared definitions for the row-wise dot-product accumulator:
// FSM encoding, security-level codes and per-level beat counts for T=16.
package dot_row_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Security-level codes as presented on i_sec_lev
    localparam logic [2:0] SEC_L1 = 3'd1;
    localparam logic [2:0] SEC_L3 = 3'd3;
    localparam logic [2:0] SEC_L5 = 3'd5;

    // Beats per row for each level when T=16
    localparam int BEATS_L1 = 40;
    localparam int BEATS_L3 = 61;
    localparam int BEATS_L5 = 84;

    // Beat count software should program for a given level (0 if unknown)
    function automatic int beats_for_level(input logic [2:0] lev);
        case (lev)
            SEC_L1:  return BEATS_L1;
            SEC_L3:  return BEATS_L3;
            SEC_L5:  return BEATS_L5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/dot_row_acc_tree_add.sv
// Lane reducer: sums T lanes of WIDTH bits (mod 2^WIDTH). In mode 0 the
// running element is added too, so the output is the next accumulator value.
// Mode 1 reduces the lanes alone. Optional MSB clear for level-1 arithmetic.
module tree_add #(
    parameter int T     = 16,
    parameter int WIDTH = 16
) (
    input  logic               i_mode,
    input  logic               i_clear_msb,
    input  logic [T*WIDTH-1:0] i_array,
    input  logic [WIDTH-1:0]   i_element,
    output logic [WIDTH-1:0]   o_element
);

    logic [WIDTH-1:0] sum;

    // Combinational reduction of all lanes plus the optional running element
    always_comb begin
        // NOTE: sum gets a value before any conditional use, so no latch is
        // inferred; blocking '=' is correct here because each loop step reads
        // the value written by the step before it.
        sum = (i_mode == 1'b0) ? i_element : '0;
        for (int j = 0; j < T; j++) begin
            sum = sum + i_array[j*WIDTH +: WIDTH];
        end
        if (i_clear_msb) begin
            sum[WIDTH-1] = 1'b0;
        end
    end

    assign o_element = sum;

endmodule

// File: rtl/dot_row_acc.sv
// Row-wise dot-product accumulator. Accepts T-lane product beats, folds each
// beat into a running sum through tree_add and, on the last beat of a row,
// moves the sum into a single-entry holding register presented on a
// valid/ready interface. The next row accumulates while a result is held.
module dot_row_acc
    import dot_row_acc_pkg::*;
#(
    parameter int T      = 16,
    parameter int WIDTH  = 16,
    parameter int BEAT_W = 8,
    parameter int ROW_W  = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [2:0]         i_sec_lev,
    input  logic               i_start,
    input  logic [BEAT_W-1:0]  i_n_beats,
    input  logic [ROW_W-1:0]   i_n_rows,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [T*WIDTH-1:0] i_prod,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_sum,
    output logic [ROW_W-1:0]   o_row_idx,
    output logic               o_busy,
    output logic               o_done
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [BEAT_W-1:0]  n_beats;
    logic [ROW_W-1:0]   row_cnt;
    logic [ROW_W-1:0]   n_rows;
    logic [2:0]         sec_lev;
    logic [WIDTH-1:0]   hold;
    logic [ROW_W-1:0]   hold_idx;
    logic               hold_valid;

    logic is_last_beat;
    logic is_last_row;
    logic accept;
    logic consume;

    // n_beats / n_rows are latched with 0 promoted to 1, so the "-1" never wraps
    assign is_last_beat = (beat_cnt == n_beats - BEAT_W'(1));
    assign is_last_row  = (row_cnt  == n_rows  - ROW_W'(1));
    assign consume      = hold_valid & i_ready;

    // A held, undrained result blocks only the beat that would overwrite it
    assign o_ready = (state == ST_ACC) & ~(is_last_beat & hold_valid & ~i_ready);
    assign accept  = i_valid & o_ready;

    tree_add #(
        .T     (T),
        .WIDTH (WIDTH)
    ) u_tree_add (
        .i_mode      (1'b0),
        .i_clear_msb (sec_lev == SEC_L1),
        .i_array     (i_prod),
        .i_element   (acc),
        .o_element   (acc_next)
    );

    assign o_valid   = hold_valid;
    assign o_sum     = hold;
    assign o_row_idx = hold_idx;
    assign o_busy    = (state != ST_IDLE);

    // Job FSM, beat/row counters, accumulator and output holding register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: every register here, including the holding register, is
            // reset so an aborted job can never leak a partial row result.
            state      <= ST_IDLE;
            acc        <= '0;
            beat_cnt   <= '0;
            row_cnt    <= '0;
            n_beats    <= '0;
            n_rows     <= '0;
            sec_lev    <= '0;
            hold       <= '0;
            hold_idx   <= '0;
            hold_valid <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' keeps every register update based on
            // the pre-edge values, whatever order the branches below run in.
            o_done <= 1'b0;
            // Consume first; a row completing in the same cycle reloads below
            if (consume) begin
                hold_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        n_beats  <= (i_n_beats == '0) ? BEAT_W'(1) : i_n_beats;
                        n_rows   <= (i_n_rows  == '0) ? ROW_W'(1)  : i_n_rows;
                        sec_lev  <= i_sec_lev;
                        acc      <= '0;
                        beat_cnt <= '0;
                        row_cnt  <= '0;
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        if (is_last_beat) begin
                            hold       <= acc_next;
                            hold_idx   <= row_cnt;
                            hold_valid <= 1'b1;
                            acc        <= '0;
                            beat_cnt   <= '0;
                            row_cnt    <= row_cnt + ROW_W'(1);
                            if (is_last_row) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            acc      <= acc_next;
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (consume) begin
                        state  <= ST_IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_row_acc.sv
// Bench for dot_row_acc: randomized and directed jobs checked against a
// row-sum reference model with a produced-but-unconsumed result queue.
module tb_dot_row_acc;

    localparam int T      = 16;
    localparam int WIDTH  = 16;
    localparam int BEAT_W = 8;
    localparam int ROW_W  = 11;
    localparam int MAX_CYC = 4000;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [2:0]         i_sec_lev;
    logic               i_start;
    logic [BEAT_W-1:0]  i_n_beats;
    logic [ROW_W-1:0]   i_n_rows;
    logic               i_valid;
    logic               o_ready;
    logic [T*WIDTH-1:0] i_prod;
    logic               o_valid;
    logic               i_ready;
    logic [WIDTH-1:0]   o_sum;
    logic [ROW_W-1:0]   o_row_idx;
    logic               o_busy;
    logic               o_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    dot_row_acc #(
        .T(T), .WIDTH(WIDTH), .BEAT_W(BEAT_W), .ROW_W(ROW_W)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_sec_lev (i_sec_lev),
        .i_start   (i_start),
        .i_n_beats (i_n_beats),
        .i_n_rows  (i_n_rows),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_prod    (i_prod),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_row_idx (o_row_idx),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Row result: plain total of all products, reduced mod 2^15 for level 1
    function automatic logic [31:0] row_exp(input int unsigned total, input int sec);
        return (sec == 1) ? (total % 32768) : (total % 65536);
    endfunction

    // pat: 0 random lanes, 1 lane j = j+1, 2 every lane = cval
    // rmode: 0 ready high, 1 random, 2 low for low_cycles then high
    task automatic run_job(input int nb_cfg, input int nr_cfg, input int sec,
                           input int pat, input logic [15:0] cval,
                           input int vmode, input int rmode, input int low_cycles,
                           input bit scramble, input int abort_at);
        int nb, nr, total, bptr, cyc, lane;
        bit done, popped, last, exp_valid, exp_ready;
        logic [T*WIDTH-1:0] beats[];
        int unsigned row_sum[];
        logic [31:0] q_sum[$];
        int q_idx[$];

        nb = (nb_cfg == 0) ? 1 : nb_cfg;
        nr = (nr_cfg == 0) ? 1 : nr_cfg;
        total = nb * nr;
        beats = new[total];
        row_sum = new[nr];
        for (int r = 0; r < nr; r++) row_sum[r] = 0;
        for (int b = 0; b < total; b++) begin
            for (int j = 0; j < T; j++) begin
                lane = (pat == 0) ? int'($urandom_range(0, 65535)) :
                       (pat == 1) ? (j + 1) : int'(cval);
                beats[b][j*WIDTH +: WIDTH] = WIDTH'(lane);
                row_sum[b / nb] += int'(lane);
            end
        end

        // Start cycle
        @(posedge i_clk); #1;
        i_start   = 1'b1;
        i_n_beats = BEAT_W'(nb_cfg);
        i_n_rows  = ROW_W'(nr_cfg);
        i_sec_lev = 3'(sec);
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        @(negedge i_clk);
        check("idle_busy", 32'(o_busy), 0);
        check("idle_ready", 32'(o_ready), 0);
        check("idle_valid", 32'(o_valid), 0);
        check("idle_done", 32'(o_done), 0);

        bptr = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge i_clk); #1;
            i_start = 1'b0;
            if (cyc == abort_at) begin
                i_valid = 1'b1;
                #2;
                i_rst = 1'b1;
                #1;
                check("rst_valid", 32'(o_valid), 0);
                check("rst_busy", 32'(o_busy), 0);
                check("rst_ready", 32'(o_ready), 0);
                check("rst_sum", 32'(o_sum), 0);
                @(posedge i_clk); #1;
                i_rst   = 1'b0;
                i_valid = 1'b0;
                i_ready = 1'b0;
                return;
            end
            if (cyc >= MAX_CYC) begin
                check("timeout", 1, 0);
                i_rst = 1'b1;
                #2;
                i_rst   = 1'b0;
                i_valid = 1'b0;
                return;
            end
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = (cyc >= low_cycles);
            endcase
            i_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_prod  = (bptr < total) ? beats[bptr] : {8{$urandom}};
            if (scramble) begin
                i_start   = ($urandom_range(0, 3) == 0);
                i_n_beats = BEAT_W'($urandom);
                i_n_rows  = ROW_W'($urandom);
                i_sec_lev = 3'($urandom);
            end
            @(negedge i_clk);
            exp_valid = (q_sum.size() > 0);
            last      = (bptr < total) && ((bptr % nb) == nb - 1);
            exp_ready = (bptr < total) && !(last && exp_valid && !i_ready);
            check("o_ready", 32'(o_ready), 32'(exp_ready));
            check("o_valid", 32'(o_valid), 32'(exp_valid));
            check("o_busy", 32'(o_busy), 1);
            check("o_done", 32'(o_done), 0);
            if (exp_valid) begin
                check("o_sum", 32'(o_sum), q_sum[0]);
                check("o_row_idx", 32'(o_row_idx), 32'(q_idx[0]));
            end
            popped = 1'b0;
            if (exp_valid && i_ready) begin
                void'(q_sum.pop_front());
                void'(q_idx.pop_front());
                popped = 1'b1;
            end
            if (i_valid && exp_ready) begin
                if (last) begin
                    q_sum.push_back(row_exp(row_sum[bptr / nb], sec));
                    q_idx.push_back(bptr / nb);
                end
                bptr++;
            end
            if (popped && q_sum.size() == 0 && bptr == total) done = 1'b1;
            cyc++;
        end

        // Done pulse follows the final consume, then clears
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge i_clk);
        check("done_pulse", 32'(o_done), 1);
        check("done_busy", 32'(o_busy), 0);
        check("done_valid", 32'(o_valid), 0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("done_clear", 32'(o_done), 0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_sec_lev = 3'd0;
        i_start   = 1'b0;
        i_n_beats = '0;
        i_n_rows  = '0;
        i_valid   = 1'b0;
        i_prod    = '0;
        i_ready   = 1'b0;
        #12;
        check("rst_o_valid", 32'(o_valid), 0);
        check("rst_o_busy", 32'(o_busy), 0);
        check("rst_o_ready", 32'(o_ready), 0);
        check("rst_o_done", 32'(o_done), 0);
        check("rst_o_sum", 32'(o_sum), 0);
        check("rst_o_row_idx", 32'(o_row_idx), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Single beat, single row, lanes 1..16 -> 136
        run_job(1, 1, 5, 1, 16'h0000, 0, 0, 0, 1'b0, -1);
        // Constant 0x1000 over 3 beats wraps to 0
        run_job(3, 2, 5, 2, 16'h1000, 0, 0, 0, 1'b0, -1);
        // Level 1: 0x9000 has its MSB cleared -> 0x1000
        run_job(1, 2, 1, 2, 16'h0900, 0, 0, 0, 1'b0, -1);
        // Output held while downstream stalls; second row's last beat waits
        run_job(2, 3, 5, 0, 16'h0000, 0, 2, 12, 1'b0, -1);
        // Full throughput with i_start and config churn mid-job
        run_job(4, 3, 3, 0, 16'h0000, 0, 0, 0, 1'b1, -1);
        // Zero beats / rows behave as one
        run_job(0, 0, 1, 0, 16'h0000, 1, 1, 0, 1'b0, -1);
        // Reset mid-job while a result is held, then a clean job
        run_job(2, 4, 5, 0, 16'h0000, 0, 2, 100, 1'b0, 5);
        run_job(3, 2, 5, 1, 16'h0000, 0, 0, 0, 1'b0, -1);
        // Random jobs
        for (int k = 0; k < 10; k++) begin
            run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 3 : 5),
                    0, 16'h0000, int'($urandom_range(0, 1)), 1, 0,
                    1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
